board_renderer: RTL and testbench
=================================

# board_renderer

Pixel source for the Tetris display path: sits directly upstream of the VGA timing controller and drives its 8-bit RGB input (RRRGGGBB). It rebuilds the current pixel coordinate from the controller's `pixel_en` and `v_sync` outputs, reads a 10×20 playfield cell memory, and maps each cell's colour index through a fixed palette. It also pulses `frame_done` at the start of vertical blanking, so game logic can update the board tear-free.

## Interface
- `PIX_DIV`, 20: clocks per displayed pixel while `pixel_en` is high.
- `X0`, 240: left pixel column of the playfield.
- `Y0`, 80: top pixel row of the playfield.
- `CELL_SHIFT`, 4: log2 of cell size in pixels (16×16 cells).
- `clk`  in  1  system clock; the same clock as the VGA controller.
- `rst`  in  1  reset, synchronous and active-high.
- `pixel_en`  in  1  active-video qualifier from the VGA controller.
- `v_sync`  in  1  vertical sync from the VGA controller; low marks vertical blanking.
- `cell_addr`  out  8  playfield memory address, `row*10 + col` (0..199).
- `cell_data`  in  3  colour index, valid one clock after `cell_addr` (synchronous read).
- `rgb_8`  out  8  pixel colour to the VGA controller.
- `frame_done`  out  1  one-clock pulse on each falling edge of `v_sync`.

## Operation
- **Column tracking.**
  - `div_cnt` counts 0..`PIX_DIV`-1 while `pixel_en`=1; `x` increments when `div_cnt` wraps.
  - `x` saturates at 1023 (10 bits).
  - `div_cnt` and `x` clear to 0 on any clock with `pixel_en`=0.
- **Row tracking.**
  - `y` (10 bits) increments on the falling edge of `pixel_en`, i.e. end of a visible line.
  - `y` clears to 0 on every clock with `v_sync`=0.
  - `y` saturates at 1023.
- **Region decode (stage 0).**
  - In board: `X0`≤x<`X0`+160 and `Y0`≤y<`Y0`+320.
  - In border: 4-pixel ring immediately outside the board.
  - Otherwise: background.
  - `col = (x-X0)>>CELL_SHIFT`, `row = (y-Y0)>>CELL_SHIFT`.
  - `cell_addr = row*10 + col`, computed as `(row<<3)+(row<<1)+col`, 8 bits. It is held at its last value outside the board.
- **Stage 1.** Registers the region code (board/border/background) and a delayed `pixel_en` alongside the memory read.
- **Stage 2.** Registers `rgb_8`:
  - delayed `pixel_en`=0: 8'h00
  - border: 8'hB6
  - background: 8'h00
  - board: palette[`cell_data`]
- **Palette** (shared package):
  - 0 empty 8'h24
  - 1 I 8'h1F
  - 2 O 8'hFC
  - 3 T 8'hA3
  - 4 S 8'h1C
  - 5 Z 8'hE0
  - 6 J 8'h03
  - 7 L 8'hF0
- **`frame_done`** = registered `v_sync_d & ~v_sync`.

## Timing
- Reset state: `rgb_8`=0, `frame_done`=0, `cell_addr`=0, `x`=`y`=`div_cnt`=0, all delay registers and `v_sync_d`/`pixel_en_d` = 0.
- Latency: `rgb_8` reflects the pixel at (x,y) 2 clocks after that pixel's first clock. This is negligible against `PIX_DIV`; no compensation is required.
- `pixel_en` falling and `v_sync` low in the same clock: the clear wins, so `y`=0.
- `frame_done` fires exactly once per frame, 1 clock after the `v_sync` fall. A `v_sync` fall coincident with reset release gives no pulse.
- Reset asserted mid-line: all state clears the next edge. The first full line after reset starts at `y`=0 only once `v_sync` has been observed low; before that, `y` is undefined-but-bounded by saturation.
- `cell_data` is sampled only in stage 1, and only when the stage-1 region is board.

## Structure
- Shared package `tetris_pkg`:
  - `BOARD_W`=10, `BOARD_H`=20
  - colour-index enum (EMPTY, I, O, T, S, Z, J, L)
  - `PALETTE` constant array
  - `BORDER_RGB`, `BG_RGB`
- Natural sub-module `pixel_coord_tracker`: `div_cnt`/`x`/`y`/`frame_done` generation from `pixel_en` and `v_sync`. Region decode and palette stay in `board_renderer`.

## Test plan
- Reset with `pixel_en`=1 → `rgb_8`=0, `frame_done`=0, `cell_addr`=0 the clock after the reset edge.
- `v_sync` low then high, 81 lines of `pixel_en` high for 12800 clocks each, memory filled with index=`addr`%8:
  - on line y=80, x=240 → `cell_addr`=0, `rgb_8`=8'h24 two clocks later;
  - x=256 → `cell_addr`=1, `rgb_8`=8'h1F.
- Line y=80, x=238 → `rgb_8`=8'hB6 (border). Line y=80, x=100 → 8'h00.
- Row 19 col 9 (y=384, x=384) → `cell_addr`=199; memory index 7 → `rgb_8`=8'hF0.
- `v_sync` 1→0 → single-clock `frame_done` pulse one clock later and `y` cleared. Holding `v_sync` low 2 lines → no further pulses.
- Assert `rst` mid-line at x=300 → next clock `x`=0, `rgb_8`=0. Resume without a `v_sync` low: `y` stays bounded at saturation ≤1023, with no X on outputs.

Source files
------------

// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared playfield geometry, colour indices and palette
package tetris_pkg;

  localparam int BOARD_W  = 10;
  localparam int BOARD_H  = 20;
  localparam int BORDER_W = 4;

  typedef enum logic [2:0] {EMPTY, I, O, T, S, Z, J, L} color_e;

  localparam logic [7:0] PALETTE [8] = '{
    8'h24,  // EMPTY
    8'h1F,  // I
    8'hFC,  // O
    8'hA3,  // T
    8'h1C,  // S
    8'hE0,  // Z
    8'h03,  // J
    8'hF0   // L
  };

  localparam logic [7:0] BORDER_RGB = 8'hB6;
  localparam logic [7:0] BG_RGB     = 8'h00;

  typedef enum logic [1:0] {RGN_BG, RGN_BORDER, RGN_BOARD} region_e;

endpackage

// File: rtl/pixel_coord_tracker.sv
// rtl/pixel_coord_tracker.sv - rebuilds x/y from VGA qualifiers and flags frame start
module pixel_coord_tracker #(
  parameter int PIX_DIV = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pixel_en,
  input  logic       v_sync,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       pixel_en_d,
  output logic       frame_done
);

  localparam int             DW        = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST  = DW'(PIX_DIV - 1);
  localparam logic [9:0]     COORD_MAX = 10'd1023;

  logic [DW-1:0] div_cnt;
  logic          v_sync_d;

  // Column: divide clocks down to pixels, saturate at the right edge, clear outside active video
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      x       <= '0;
    end else if (!pixel_en) begin
      div_cnt <= '0;
      x       <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      if (x != COORD_MAX) x <= x + 10'd1;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Row: advance at the end of each visible line; vertical blanking clear takes priority
  always_ff @(posedge clk) begin
    if (rst) begin
      y          <= '0;
      pixel_en_d <= 1'b0;
    end else begin
      pixel_en_d <= pixel_en;
      if (!v_sync) begin
        y <= '0;
      end else if (pixel_en_d && !pixel_en && (y != COORD_MAX)) begin
        y <= y + 10'd1;
      end
    end
  end

  // Frame start: one-clock pulse when v_sync falls into blanking
  always_ff @(posedge clk) begin
    if (rst) begin
      v_sync_d   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      v_sync_d   <= v_sync;
      frame_done <= v_sync_d & ~v_sync;
    end
  end

endmodule

// File: rtl/board_renderer.sv
// rtl/board_renderer.sv - playfield pixel source: region decode, cell fetch, palette lookup
module board_renderer
  import tetris_pkg::*;
#(
  parameter int PIX_DIV    = 20,
  parameter int X0         = 240,
  parameter int Y0         = 80,
  parameter int CELL_SHIFT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pixel_en,
  input  logic       v_sync,
  output logic [7:0] cell_addr,
  input  logic [2:0] cell_data,
  output logic [7:0] rgb_8,
  output logic       frame_done
);

  localparam int CELL_PX = 1 << CELL_SHIFT;

  localparam logic [10:0] BX_LO = 11'(X0);
  localparam logic [10:0] BX_HI = 11'(X0 + BOARD_W * CELL_PX);
  localparam logic [10:0] BY_LO = 11'(Y0);
  localparam logic [10:0] BY_HI = 11'(Y0 + BOARD_H * CELL_PX);
  localparam logic [10:0] RX_LO = 11'(X0 - BORDER_W);
  localparam logic [10:0] RX_HI = 11'(X0 + BOARD_W * CELL_PX + BORDER_W);
  localparam logic [10:0] RY_LO = 11'(Y0 - BORDER_W);
  localparam logic [10:0] RY_HI = 11'(Y0 + BOARD_H * CELL_PX + BORDER_W);

  logic [9:0]  x, y;
  logic        pen_d;
  logic [10:0] xe, ye;
  logic [9:0]  dx, dy;
  logic [3:0]  col;
  logic [4:0]  row;
  logic [7:0]  addr_calc;
  logic [7:0]  addr_hold;
  logic        in_board, in_ring;
  region_e     rgn_s0, rgn_s1;
  logic        pen_s1;

  pixel_coord_tracker #(.PIX_DIV(PIX_DIV)) u_trk (
    .clk        (clk),
    .rst        (rst),
    .pixel_en   (pixel_en),
    .v_sync     (v_sync),
    .x          (x),
    .y          (y),
    .pixel_en_d (pen_d),
    .frame_done (frame_done)
  );

  assign xe = {1'b0, x};
  assign ye = {1'b0, y};
  assign dx = x - 10'(X0);
  assign dy = y - 10'(Y0);
  assign col = 4'(dx >> CELL_SHIFT);
  assign row = 5'(dy >> CELL_SHIFT);

  // row*10 + col without a multiplier
  assign addr_calc = {row, 3'b000} + {2'b00, row, 1'b0} + {4'b0000, col};

  assign in_board = (xe >= BX_LO) && (xe < BX_HI) && (ye >= BY_LO) && (ye < BY_HI);
  assign in_ring  = (xe >= RX_LO) && (xe < RX_HI) && (ye >= RY_LO) && (ye < RY_HI);

  // Stage 0: classify the current pixel; the ring test only matters outside the board
  always_comb begin
    rgn_s0 = RGN_BG;
    if (in_board) begin
      rgn_s0 = RGN_BOARD;
    end else if (in_ring) begin
      rgn_s0 = RGN_BORDER;
    end
  end

  assign cell_addr = in_board ? addr_calc : addr_hold;

  // Keep the last in-board address so the memory port is quiet off the board
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_hold <= '0;
    end else if (in_board) begin
      addr_hold <= addr_calc;
    end
  end

  // Stage 1: carry region and video qualifier alongside the memory read
  always_ff @(posedge clk) begin
    if (rst) begin
      rgn_s1 <= RGN_BG;
      pen_s1 <= 1'b0;
    end else begin
      rgn_s1 <= rgn_s0;
      pen_s1 <= pen_d;
    end
  end

  // Stage 2: final colour; cell_data is only consulted for board pixels
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_8 <= 8'h00;
    end else if (!pen_s1) begin
      rgb_8 <= 8'h00;
    end else begin
      case (rgn_s1)
        RGN_BORDER: rgb_8 <= BORDER_RGB;
        RGN_BOARD:  rgb_8 <= PALETTE[cell_data];
        default:    rgb_8 <= BG_RGB;
      endcase
    end
  end

endmodule

// File: tb/tb_board_renderer.sv
// tb/tb_board_renderer.sv - self-checking bench for board_renderer
module tb_board_renderer;

  localparam int PD = 3;
  localparam logic [7:0] PAL [8] = '{8'h24, 8'h1F, 8'hFC, 8'hA3, 8'h1C, 8'hE0, 8'h03, 8'hF0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pixel_en = 1'b1;
  logic       v_sync = 1'b1;
  logic [7:0] cell_addr;
  logic [2:0] cell_data;
  logic [7:0] rgb_8;
  logic       frame_done;

  int n_chk = 0;
  int n_fail = 0;

  board_renderer #(.PIX_DIV(PD), .X0(240), .Y0(80), .CELL_SHIFT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .pixel_en   (pixel_en),
    .v_sync     (v_sync),
    .cell_addr  (cell_addr),
    .cell_data  (cell_data),
    .rgb_8      (rgb_8),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // playfield memory: index = addr % 8, one clock read latency
  always @(posedge clk) cell_data <= cell_addr[2:0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic err(input string name);
    n_fail++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // reference model state, advanced on each active edge
  int   n_m = 0;
  int   y_m = 0;
  bit   pen_m = 0, vs_m = 0, fd_m = 0, rst_m = 0;
  logic [7:0] hold_m = 8'h00;
  logic [7:0] q [$];

  always @(posedge clk) begin
    rst_m = rst;
    if (rst) begin
      n_m = 0; y_m = 0; pen_m = 0; vs_m = 0; fd_m = 0;
    end else begin
      fd_m = vs_m && !v_sync;
      vs_m = v_sync;
      if (!v_sync) y_m = 0;
      else if (pen_m && !pixel_en && y_m < 1023) y_m++;
      n_m = pixel_en ? n_m + 1 : 0;
      pen_m = pixel_en;
    end
  end

  function automatic int cur_x();
    return (n_m / PD > 1023) ? 1023 : n_m / PD;
  endfunction

  function automatic bit on_board(int xx, int yy);
    return xx >= 240 && xx < 400 && yy >= 80 && yy < 400;
  endfunction

  function automatic int addr_of(int xx, int yy);
    return ((yy - 80) / 16) * 10 + (xx - 240) / 16;
  endfunction

  function automatic logic [7:0] exp_rgb(int xx, int yy, bit pen);
    if (!pen) return 8'h00;
    if (on_board(xx, yy)) return PAL[addr_of(xx, yy) % 8];
    if (xx >= 236 && xx < 404 && yy >= 76 && yy < 404) return 8'hB6;
    return 8'h00;
  endfunction

  // scoreboard: expected colour queued per clock, compared two clocks later
  always @(negedge clk) begin
    int xm;
    logic [7:0] ea;
    xm = cur_x();
    if (rst_m) begin
      q.delete();
      q.push_back(8'h00);
      hold_m = 8'h00;
      chk("rgb_in_reset", rgb_8, 8'h00);
    end else if (q.size() >= 2) begin
      chk("rgb_pipe", rgb_8, q.pop_front());
    end
    q.push_back(exp_rgb(xm, y_m, pen_m));
    if (on_board(xm, y_m)) begin
      ea = 8'(addr_of(xm, y_m));
      hold_m = ea;
    end else begin
      ea = hold_m;
    end
    chk("cell_addr", cell_addr, ea);
    chk("frame_done", frame_done, fd_m);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic short_line();
    pixel_en = 1'b1; tick();
    pixel_en = 1'b0; tick();
  endtask

  task automatic check_point(input int yy, input int xx, input int ea, input bit ca, input logic [7:0] er);
    int g;
    if (pixel_en && (y_m != yy || cur_x() > xx)) begin
      pixel_en = 1'b0;
      tick();
    end
    g = 0;
    while (y_m < yy && g < 3000) begin short_line(); g++; end
    if (y_m != yy) err($sformatf("reach_row_%0d", yy));
    pixel_en = 1'b1;
    g = 0;
    while (cur_x() < xx && g < 5000) begin tick(); g++; end
    if (cur_x() != xx) err($sformatf("reach_col_%0d", xx));
    if (ca) chk($sformatf("addr_y%0d_x%0d", yy, xx), cell_addr, ea);
    tick();
    tick();
    chk($sformatf("rgb_y%0d_x%0d", yy, xx), rgb_8, er);
  endtask

  typedef struct {
    int         y;
    int         x;
    int         addr;
    bit         ca;
    logic [7:0] rgb;
  } vec_t;

  vec_t tbl [17];

  initial begin
    int cnt;
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
    cnt = 0;
  end

  initial begin
    int cnt;
    tbl = '{
      '{75,  300, 0,   0, 8'h00},
      '{79,  300, 0,   0, 8'hB6},
      '{80,  100, 0,   0, 8'h00},
      '{80,  238, 0,   0, 8'hB6},
      '{80,  240, 0,   1, 8'h24},
      '{80,  256, 1,   1, 8'h1F},
      '{80,  399, 9,   1, 8'h1F},
      '{80,  400, 0,   0, 8'hB6},
      '{80,  404, 0,   0, 8'h00},
      '{95,  240, 0,   1, 8'h24},
      '{96,  250, 10,  1, 8'hFC},
      '{200, 300, 73,  1, 8'h1F},
      '{384, 384, 199, 1, 8'hF0},
      '{399, 399, 199, 1, 8'hF0},
      '{400, 300, 0,   0, 8'hB6},
      '{403, 236, 0,   0, 8'hB6},
      '{404, 300, 0,   0, 8'h00}
    };

    // reset with pixel_en high
    tick();
    chk("rst_rgb", rgb_8, 8'h00);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_cell_addr", cell_addr, 8'h00);
    tick();
    rst = 1'b0;
    pixel_en = 1'b0;
    tick();

    // frame start
    v_sync = 1'b0; tick();
    chk("fd_first", frame_done, 1'b1);
    tick();
    chk("fd_first_single", frame_done, 1'b0);
    v_sync = 1'b1; tick();

    for (int i = 0; i < 17; i++) begin
      check_point(tbl[i].y, tbl[i].x, tbl[i].addr, tbl[i].ca, tbl[i].rgb);
    end

    // end of frame: single pulse, none while blanking persists
    pixel_en = 1'b0; tick();
    v_sync = 1'b0; tick();
    chk("fd_pulse", frame_done, 1'b1);
    tick();
    chk("fd_single", frame_done, 1'b0);
    cnt = 0;
    repeat (2) begin
      pixel_en = 1'b1;
      repeat (5) begin tick(); cnt += int'(frame_done); end
      pixel_en = 1'b0;
      repeat (2) begin tick(); cnt += int'(frame_done); end
    end
    chk("fd_no_repeat", cnt, 0);
    v_sync = 1'b1; tick();

    // y restarted from 0 after blanking
    check_point(80, 240, 0, 1, 8'h24);

    // x saturation on a board row: a wrapping x would land back on the board
    check_point(200, 1023, 0, 0, 8'h00);
    repeat (300 * PD) tick();

    // reset mid-line
    check_point(210, 300, 83, 1, 8'hA3);
    rst = 1'b1; tick();
    chk("rst_mid_rgb", rgb_8, 8'h00);
    chk("rst_mid_addr", cell_addr, 8'h00);
    chk("rst_mid_fd", frame_done, 1'b0);
    rst = 1'b0;
    repeat (4) tick();
    pixel_en = 1'b0; tick();

    // no v_sync low: y saturates; a wrapped y would reach the board at row 80
    repeat (1110) short_line();
    check_point(1023, 300, 0, 0, 8'h00);

    // v_sync falling exactly at reset release
    pixel_en = 1'b0;
    rst = 1'b1; tick();
    rst = 1'b0; v_sync = 1'b0; tick();
    chk("fd_rst_release_0", frame_done, 1'b0);
    tick();
    chk("fd_rst_release_1", frame_done, 1'b0);
    v_sync = 1'b1;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
